// File: rtl/xilly_stream_host_pkg.sv
// Shared definitions for the Xillybus loopback stream host.
//   state_t      : run-control FSM states
//   IDX_W        : width of word indices and of the error/index status outputs
//   pattern_word : test pattern for word k, {16'(2k+1), 16'(2k)} (wraps mod 2^16)
package xilly_host_pkg;

  localparam int unsigned IDX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_OPENING,
    ST_RUN,
    ST_DONE
  } state_t;

  // The low half is 2k truncated to IDX_W bits; it is always even, so the
  // high half 2k+1 only differs by forcing bit 0 to one.
  function automatic logic [31:0] pattern_word(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] lo;
    lo = {k[IDX_W-2:0], 1'b0};
    return {lo[IDX_W-1:1], 1'b1, lo};
  endfunction

endpackage

// File: rtl/xilly_pattern_gen.sv
// Pattern word generator: maps a word index to its 32-bit test word.
//   idx  : word index
//   word : pattern word for idx
module xilly_pattern_gen
  import xilly_host_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [31:0]      word
);

  assign word = pattern_word(idx);

endmodule

// File: rtl/xilly_stream_host.sv
// Loopback stream host: writes WORDS pattern words to the user write FIFO,
// reads them back from the user read FIFO and checks each one.
//   bus_clk / quiesce          : clock, synchronous active-high reset
//   start                      : pulse to begin a run (IDLE or DONE only)
//   user_w_write_32_*          : write strobe/data/full/open
//   user_r_read_32_*           : read strobe/data/empty/open
//   busy/done/pass/timeout     : run status
//   err_count / first_err_idx  : mismatch count and first mismatching index
module xilly_stream_host
  import xilly_host_pkg::*;
#(
  parameter int unsigned WORDS    = 1024,
  parameter int unsigned OPEN_DLY = 5,
  parameter int unsigned TIMEOUT  = 4096
) (
  input  logic        bus_clk,
  input  logic        quiesce,
  input  logic        start,
  output logic        user_w_write_32_wren,
  output logic [31:0] user_w_write_32_data,
  input  logic        user_w_write_32_full,
  output logic        user_w_write_32_open,
  output logic        user_r_read_32_rden,
  input  logic [31:0] user_r_read_32_data,
  input  logic        user_r_read_32_empty,
  output logic        user_r_read_32_open,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [15:0] first_err_idx
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS);

  state_t           state, state_next;
  logic [IDX_W-1:0] wr_idx, rd_idx, cmp_idx;
  logic             cmp_pending;
  logic [31:0]      open_cnt, idle_cnt;
  logic [31:0]      wr_word, exp_word;
  logic             in_run, wr_more, rd_more, rd_acc, go;
  logic             last_cmp, idle_hit, mismatch;

  xilly_pattern_gen u_wr_gen  (.idx(wr_idx),  .word(wr_word));
  xilly_pattern_gen u_chk_gen (.idx(cmp_idx), .word(exp_word));

  assign in_run  = (state == ST_RUN);
  assign wr_more = (wr_idx < LAST);
  assign rd_more = (rd_idx < LAST);
  assign rd_acc  = in_run && rd_more && !user_r_read_32_empty;
  assign go      = start && (state == ST_IDLE || state == ST_DONE);

  assign user_w_write_32_wren = in_run && wr_more && !user_w_write_32_full;
  assign user_w_write_32_data = user_w_write_32_wren ? wr_word : '0;
  assign user_r_read_32_rden  = rd_acc;

  assign busy                 = (state == ST_OPENING) || in_run;
  assign user_w_write_32_open = busy;
  assign user_r_read_32_open  = busy;
  assign done                 = (state == ST_DONE);
  assign pass                 = done && (err_count == '0) && !timeout;

  // A pending compare with every read already issued is the final word.
  assign last_cmp = in_run && cmp_pending && !rd_more;
  assign idle_hit = in_run && rd_more && !rd_acc && (idle_cnt + 32'd1 >= 32'(TIMEOUT));
  assign mismatch = cmp_pending && (user_r_read_32_data != exp_word);

  always_ff @(posedge bus_clk) begin
    if (quiesce) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_OPENING;
      ST_OPENING:       if (open_cnt + 32'd1 >= 32'(OPEN_DLY)) state_next = ST_RUN;
      ST_RUN:           if (last_cmp || idle_hit) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (quiesce) begin
      wr_idx        <= '0;
      rd_idx        <= '0;
      cmp_idx       <= '0;
      cmp_pending   <= 1'b0;
      open_cnt      <= '0;
      idle_cnt      <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      timeout       <= 1'b0;
    end else if (go) begin
      wr_idx        <= '0;
      rd_idx        <= '0;
      cmp_idx       <= '0;
      cmp_pending   <= 1'b0;
      open_cnt      <= '0;
      idle_cnt      <= '0;
      err_count     <= '0;
      first_err_idx <= '0;
      timeout       <= 1'b0;
    end else begin
      if (state == ST_OPENING) open_cnt <= open_cnt + 32'd1;
      if (user_w_write_32_wren) wr_idx <= wr_idx + 1'b1;
      // Read data arrives the cycle after rden; remember which word it is.
      cmp_pending <= rd_acc;
      if (rd_acc) begin
        cmp_idx  <= rd_idx;
        rd_idx   <= rd_idx + 1'b1;
        idle_cnt <= '0;
      end else if (in_run && rd_more) begin
        idle_cnt <= idle_cnt + 32'd1;
      end
      if (idle_hit) timeout <= 1'b1;
      if (mismatch) begin
        if (err_count != '1) err_count <= err_count + 1'b1;
        if (err_count == '0) first_err_idx <= cmp_idx;
      end
    end
  end

endmodule

// File: tb/tb_xilly_stream_host.sv
// Scoreboard bench for xilly_stream_host: an ideal zero-latency loopback FIFO
// shared by two hosts (WORDS=1024 and WORDS=40000; only one runs at a time).
module tb_xilly_stream_host;

  localparam int W0   = 1024;
  localparam int W1   = 40000;
  localparam int ODLY = 5;
  localparam int TMO  = 4096;

  typedef struct {
    logic pass;
    logic tout;
    int   errs;
    int   first;
    int   busy_cyc;   // -1: not checked
  } status_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        quiesce, full, empty;
  logic [1:0]  start_v;
  logic [31:0] rdata;

  logic        wren0, rden0, wopen0, ropen0, busy0, done0, pass0, tout0;
  logic [31:0] wdata0;
  logic [15:0] errc0, ferr0;
  logic        wren1, rden1, wopen1, ropen1, busy1, done1, pass1, tout1;
  logic [31:0] wdata1;
  logic [15:0] errc1, ferr1;

  xilly_stream_host #(.WORDS(W0), .OPEN_DLY(ODLY), .TIMEOUT(TMO)) u_dut0 (
    .bus_clk(clk), .quiesce(quiesce), .start(start_v[0]),
    .user_w_write_32_wren(wren0), .user_w_write_32_data(wdata0),
    .user_w_write_32_full(full), .user_w_write_32_open(wopen0),
    .user_r_read_32_rden(rden0), .user_r_read_32_data(rdata),
    .user_r_read_32_empty(empty), .user_r_read_32_open(ropen0),
    .busy(busy0), .done(done0), .pass(pass0), .timeout(tout0),
    .err_count(errc0), .first_err_idx(ferr0)
  );

  xilly_stream_host #(.WORDS(W1), .OPEN_DLY(ODLY), .TIMEOUT(TMO)) u_dut1 (
    .bus_clk(clk), .quiesce(quiesce), .start(start_v[1]),
    .user_w_write_32_wren(wren1), .user_w_write_32_data(wdata1),
    .user_w_write_32_full(full), .user_w_write_32_open(wopen1),
    .user_r_read_32_rden(rden1), .user_r_read_32_data(rdata),
    .user_r_read_32_empty(empty), .user_r_read_32_open(ropen1),
    .busy(busy1), .done(done1), .pass(pass1), .timeout(tout1),
    .err_count(errc1), .first_err_idx(ferr1)
  );

  // Reference pattern from plain arithmetic: high half 2k+1, low half 2k, mod 2^16.
  function automatic logic [31:0] model_word(input int k);
    int lo, hi;
    lo = (2 * k) % 65536;
    hi = (2 * k + 1) % 65536;
    return {hi[15:0], lo[15:0]};
  endfunction

  // Ideal loopback FIFO
  logic [31:0] mem [0:65535];
  int          wp = 0, rp = 0;
  logic        flush, noret, rstall;
  int          corrupt_idx;

  assign empty = (wp == rp) || noret || rstall;

  always @(posedge clk) begin
    if (flush) begin
      wp    <= 0;
      rp    <= 0;
      rdata <= '0;
    end else begin
      if (wren0 || wren1) begin
        mem[wp[15:0]] <= wren0 ? wdata0 : wdata1;
        wp <= wp + 1;
      end
      if (rden0 || rden1) begin
        rdata <= (rp == corrupt_idx) ? 32'hDEADBEEF : mem[rp[15:0]];
        rp <= rp + 1;
      end
    end
  end

  // Scoreboard
  logic [31:0] exp_q[$];
  status_t     st_q[$];
  logic        act = 1'b0;
  int          n_tests = 0, n_fail = 0;
  int          wcnt = 0, bcnt = 0;
  logic        done_q = 1'b0;
  int          zero_req = 0, zero_ack = 0, tmo_req = 0, tmo_ack = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  always @(negedge clk) begin : mon
    logic        w, b, d, p, t;
    logic [31:0] wd, e;
    logic [15:0] ec, fe;
    logic [143:0] z;
    status_t     s;
    if (act == 1'b0) begin
      w = wren0; wd = wdata0; b = busy0; d = done0; p = pass0; t = tout0; ec = errc0; fe = ferr0;
    end else begin
      w = wren1; wd = wdata1; b = busy1; d = done1; p = pass1; t = tout1; ec = errc1; fe = ferr1;
    end
    if (start_v[act]) begin
      wcnt = 0;
      bcnt = 0;
    end else if (b) begin
      bcnt++;
    end
    if (full) check("wren_while_full", {31'd0, w}, 32'd0);
    if (w) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL extra_write got %h want none", wd);
      end else begin
        e = exp_q.pop_front();
        check("wr_data", wd, e);
      end
      if (wcnt == 0) check("word0", wd, 32'h00010000);
      if (act == 1'b0 && wcnt == 1023) check("word1023", wd, 32'h07FF07FE);
      if (act == 1'b1 && wcnt == 32768) check("word32768", wd, 32'h00010000);
      wcnt++;
    end
    if (d && !done_q) begin
      if (st_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done got 1 want 0");
      end else begin
        s = st_q.pop_front();
        check("pass", {31'd0, p}, {31'd0, s.pass});
        check("timeout", {31'd0, t}, {31'd0, s.tout});
        check("err_count", {16'd0, ec}, s.errs);
        check("first_err_idx", {16'd0, fe}, s.first);
        check("writes_left", exp_q.size(), 32'd0);
        if (s.busy_cyc >= 0) check("busy_cycles", bcnt, s.busy_cyc);
      end
    end
    done_q = d;
    if (zero_req != zero_ack) begin
      z = {wren0, rden0, wopen0, ropen0, busy0, done0, pass0, tout0, wdata0, errc0, ferr0,
           wren1, rden1, wopen1, ropen1, busy1, done1, pass1, tout1, wdata1, errc1, ferr1};
      n_tests++;
      if (z != '0) begin
        n_fail++;
        $display("FAIL outputs_zero got %h want 0", z);
      end
      zero_ack = zero_req;
    end
    if (tmo_req != tmo_ack) begin
      n_tests++;
      n_fail++;
      $display("FAIL run_budget got expired want done");
      tmo_ack = tmo_req;
    end
  end

  task automatic do_flush();
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
  endtask

  task automatic pulse_start(input logic u);
    @(posedge clk); #1 start_v[u] = 1'b1;
    @(posedge clk); #1 start_v[u] = 1'b0;
  endtask

  // mode 0: clean, 1: full held for 50 cycles mid-run, 2: random full/read stalls
  task automatic do_run(input logic u, input int words, input int mode, input int budget,
                        input logic ep, input logic et, input int ee, input int ef, input int eb);
    status_t s;
    int      cyc;
    act = u;
    for (int k = 0; k < words; k++) exp_q.push_back(model_word(k));
    s.pass = ep; s.tout = et; s.errs = ee; s.first = ef; s.busy_cyc = eb;
    st_q.push_back(s);
    pulse_start(u);
    cyc = 0;
    while (!(u ? done1 : done0) && cyc < budget) begin
      if (mode == 1) full = (cyc >= 300 && cyc < 350);
      if (mode == 2) begin
        full   = ($urandom_range(0, 3) == 0);
        rstall = ($urandom_range(0, 3) == 0);
      end
      @(posedge clk); #1;
      cyc++;
    end
    full   = 1'b0;
    rstall = 1'b0;
    if (!(u ? done1 : done0)) begin
      tmo_req++;
      exp_q.delete();
      st_q.delete();
      quiesce = 1'b1;
      @(posedge clk); #1 quiesce = 1'b0;
    end
    do_flush();
  endtask

  initial begin
    quiesce = 1'b1; full = 1'b0; start_v = '0; flush = 1'b1;
    noret = 1'b0; rstall = 1'b0; corrupt_idx = -1;
    repeat (3) @(posedge clk);
    #1 quiesce = 1'b0; flush = 1'b0;
    zero_req++;
    @(posedge clk); #1;

    do_run(1'b0, W0, 0, 3000, 1'b1, 1'b0, 0, 0, -1);
    do_run(1'b0, W0, 1, 3000, 1'b1, 1'b0, 0, 0, -1);

    corrupt_idx = 10;
    do_run(1'b0, W0, 0, 3000, 1'b0, 1'b0, 1, 10, -1);

    corrupt_idx = -1;
    noret = 1'b1;
    do_run(1'b0, W0, 0, 6000, 1'b0, 1'b1, 0, 0, ODLY + TMO);
    noret = 1'b0;

    for (int i = 0; i < 2; i++) do_run(1'b0, W0, 2, 6000, 1'b1, 1'b0, 0, 0, -1);
    corrupt_idx = $urandom_range(0, W0 - 1);
    do_run(1'b0, W0, 2, 6000, 1'b0, 1'b0, 1, corrupt_idx, -1);
    corrupt_idx = -1;

    // Quiesce mid-run once 300 words have been read back.
    begin : q_run
      int cyc;
      act = 1'b0;
      for (int k = 0; k < W0; k++) exp_q.push_back(model_word(k));
      pulse_start(1'b0);
      cyc = 0;
      while (rp < 300 && cyc < 2000) begin
        @(posedge clk); #1;
        cyc++;
      end
      if (rp < 300) tmo_req++;
      quiesce = 1'b1;
      @(posedge clk); #1 quiesce = 1'b0;
      zero_req++;
      exp_q.delete();
      do_flush();
    end
    do_run(1'b0, W0, 0, 3000, 1'b1, 1'b0, 0, 0, -1);

    do_run(1'b1, W1, 0, 45000, 1'b1, 1'b0, 0, 0, -1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xilly_stream_host.md
XILLY_STREAM_HOST -- requirements
Module: xilly_stream_host

Interface
REQ-001 SHALL have parameter WORDS, default 1024, meaning the number of 32-bit words written and read back per run (1..65535).
REQ-002 SHALL have parameter OPEN_DLY, default 5, meaning the idle cycles between asserting the open flags and the first write.
REQ-003 SHALL have parameter TIMEOUT, default 4096, meaning the maximum consecutive cycles without a completed read before the run aborts.
REQ-004 SHALL have port bus_clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port quiesce  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  in  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
REQ-007 SHALL have port user_w_write_32_wren  out  1  write strobe to the user write FIFO.
REQ-008 SHALL have port user_w_write_32_data  out  32  write data.
REQ-009 SHALL have port user_w_write_32_full  in  1  user write FIFO full.
REQ-010 SHALL have port user_w_write_32_open  out  1  write stream open.
REQ-011 SHALL have port user_r_read_32_rden  out  1  read strobe to the user read FIFO.
REQ-012 SHALL have port user_r_read_32_data  in  32  read data, valid one cycle after an accepted rden.
REQ-013 SHALL have port user_r_read_32_empty  in  1  user read FIFO empty.
REQ-014 SHALL have port user_r_read_32_open  out  1  read stream open.
REQ-015 SHALL have ports busy/done/pass/timeout  out  1 each  run status.
REQ-016 SHALL have ports err_count  out  16  mismatch count; first_err_idx  out  16  index of the first mismatching word.

Function
REQ-017 SHALL implement the FSM IDLE -> OPENING (OPEN_DLY cycles) -> RUN -> DONE; start in DONE re-enters OPENING.
REQ-018 SHALL set both open outputs to 1 in OPENING and RUN, and to 0 in IDLE and DONE.
REQ-019 SHALL define pattern word k as {16'(2k+1), 16'(2k)} with modulo-2^16 wrap.
REQ-020 SHALL, in RUN, assert wren with word wr_idx whenever wr_idx<WORDS and full=0, and SHALL increment wr_idx the same cycle; wren SHALL be combinationally gated by full.
REQ-021 SHALL, in RUN, assert rden whenever rd_idx<WORDS and empty=0; an accepted rden SHALL increment rd_idx, and the data on the next cycle SHALL be compared against pattern word rd_idx-1.
REQ-022 SHALL run the writer and reader concurrently; a write and a read in the same cycle are both legal.
REQ-023 SHALL, on each mismatch, increment err_count (saturating at 0xFFFF) and latch first_err_idx on the first mismatch only.
REQ-024 SHALL count idle cycles with no accepted rden while rd_idx<WORDS, resetting the count on each accepted rden; reaching TIMEOUT SHALL set timeout=1 and go to DONE.
REQ-025 SHALL go to DONE one cycle after the final compare; done=1 and pass=(err_count==0 && !timeout) SHALL hold until the next start or quiesce.
REQ-026 SHALL clear the indices, err_count, first_err_idx, pass, and timeout on start; busy=1 exactly in OPENING and RUN.
REQ-027 SHALL ignore start while busy.

Reset
REQ-028 SHALL, on quiesce=1, return to IDLE the next edge, regardless of state, including mid-run.
REQ-029 SHALL reset every output to 0, including wren, rden, both open flags, data, busy, done, pass, timeout, err_count, and first_err_idx.
REQ-030 SHALL discard any in-flight read compare when reset.

Structure
REQ-031 SHALL place the FSM state enum, the 16-bit index width, and the pattern-word function in package xilly_host_pkg.
REQ-032 SHALL use one sub-module, xilly_pattern_gen (index in, 32-bit word out), instantiated twice: once for the writer and once for the checker.

Verification
REQ-033 SHALL cover a loopback with a zero-latency ideal FIFO model and WORDS=1024: word 0 = 0x00010000, word 1023 = 0x07FF07FE, pass=1, err_count=0.
REQ-034 SHALL cover full held high for 50 cycles mid-run: no wren while full, data continuous on resume, pass=1.
REQ-035 SHALL cover the model corrupting word 10 to 0xDEADBEEF: err_count=1, first_err_idx=10, pass=0.
REQ-036 SHALL cover the model never returning data: timeout=1 after 4096 idle cycles, done=1, pass=0.
REQ-037 SHALL cover quiesce asserted at word 300: all outputs 0 on the next cycle; a following start completes with pass=1.
REQ-038 SHALL cover WORDS=40000: the pattern wraps (word 32768 = 0x00010000), and pass=1.
